// File: rtl/uart_tx_serializer.sv
// 8N1 / 8E1 / 8O1 UART transmitter fed by the Tx data and send registers; tx falls one cycle after the send trigger.
// No backpressure: a send outside IDLE is dropped, and tx_busy / tx_fsm_in_STOP_S let the core poll for completion.
module uart_tx_serializer #(
  parameter int BAUD_DIV   = 434,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_data_en,
  input  logic [7:0] Tx_Data_w,
  input  logic       tx_send_en,
  input  logic       tx_send,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_fsm_in_STOP_S,
  output logic       tx_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  // tx_done is registered, so it is set one count early to land on the final STOP cycle.
  localparam logic [CW-1:0] DONE_AT   = CW'(BAUD_DIV - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [7:0]    hold_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          baud_last;
  logic [7:0]    send_byte;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign send_byte = tx_data_en ? Tx_Data_w : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 8'h00;
    end else if (tx_data_en) begin
      hold_q <= Tx_Data_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      tx               <= 1'b1;
      tx_busy          <= 1'b0;
      tx_fsm_in_STOP_S <= 1'b0;
      tx_done          <= 1'b0;
      shift_q          <= 8'h00;
      parity_q         <= 1'b0;
      baud_cnt         <= '0;
      bit_cnt          <= 3'd0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (tx_send_en && tx_send) begin
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            shift_q  <= send_byte;
            parity_q <= (^send_byte) ^ PARITY_ODD;
            bit_cnt  <= 3'd0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN) begin
                state <= PARITY;
                tx    <= parity_q;
              end else begin
                state            <= STOP;
                tx               <= 1'b1;
                tx_fsm_in_STOP_S <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx      <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_cnt         <= '0;
            state            <= STOP;
            tx               <= 1'b1;
            tx_fsm_in_STOP_S <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == DONE_AT) begin
            tx_done <= 1'b1;
          end
          if (baud_last) begin
            baud_cnt         <= '0;
            state            <= IDLE;
            tx_busy          <= 1'b0;
            tx_fsm_in_STOP_S <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state            <= IDLE;
          tx               <= 1'b1;
          tx_busy          <= 1'b0;
          tx_fsm_in_STOP_S <= 1'b0;
          baud_cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parity configurations share one stimulus stream,
// a frame-level model predicts every output each cycle, and literal checks pin the model.
module tb_uart_tx_serializer;

  localparam int B = 4;

  logic       clk;
  logic       rst;
  logic       tx_data_en;
  logic [7:0] Tx_Data_w;
  logic       tx_send_en;
  logic       tx_send;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;
  wire  [2:0] stop_w;
  wire  [2:0] done_w;

  int checks = 0;
  int errors = 0;

  // instance 0: even parity, 1: odd parity, 2: no parity
  int pe_a[3]  = '{1, 1, 0};
  int odd_a[3] = '{0, 1, 0};

  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .rst(rst), .tx_data_en(tx_data_en), .Tx_Data_w(Tx_Data_w),
    .tx_send_en(tx_send_en), .tx_send(tx_send), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .tx_fsm_in_STOP_S(stop_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
    .clk(clk), .rst(rst), .tx_data_en(tx_data_en), .Tx_Data_w(Tx_Data_w),
    .tx_send_en(tx_send_en), .tx_send(tx_send), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .tx_fsm_in_STOP_S(stop_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.BAUD_DIV(B), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
    .clk(clk), .rst(rst), .tx_data_en(tx_data_en), .Tx_Data_w(Tx_Data_w),
    .tx_send_en(tx_send_en), .tx_send(tx_send), .tx(tx_w[2]), .tx_busy(busy_w[2]),
    .tx_fsm_in_STOP_S(stop_w[2]), .tx_done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame model: the whole frame as a bit string, indexed by elapsed cycles / B.
  logic [10:0] m_frame[3];
  logic        m_act[3];
  int          m_off[3];
  logic [7:0]  m_hold;

  function automatic logic [10:0] frame_of(input logic [7:0] b, input int pe, input int odd);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (pe != 0) f[9] = (^b) ^ (odd != 0);
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 1'b0;
        m_off[i] <= 0;
      end
      m_hold <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_act[i]) begin
          m_off[i] <= m_off[i] + 1;
          if (m_off[i] + 1 == (10 + pe_a[i]) * B) m_act[i] <= 1'b0;
        end else if (tx_send_en && tx_send) begin
          m_act[i]   <= 1'b1;
          m_off[i]   <= 0;
          m_frame[i] <= frame_of(tx_data_en ? Tx_Data_w : m_hold, pe_a[i], odd_a[i]);
        end
      end
      if (tx_data_en) m_hold <= Tx_Data_w;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int len;
      len = 10 + pe_a[i];
      if (m_act[i]) begin
        chk($sformatf("u%0d tx", i),   tx_w[i],   m_frame[i][m_off[i] / B]);
        chk($sformatf("u%0d busy", i), busy_w[i], 1);
        chk($sformatf("u%0d stop", i), stop_w[i], (m_off[i] / B == len - 1) ? 1 : 0);
        chk($sformatf("u%0d done", i), done_w[i], (m_off[i] == len * B - 1) ? 1 : 0);
      end else begin
        chk($sformatf("u%0d tx", i),   tx_w[i],   1);
        chk($sformatf("u%0d busy", i), busy_w[i], 0);
        chk($sformatf("u%0d stop", i), stop_w[i], 0);
        chk($sformatf("u%0d done", i), done_w[i], 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data_en = 1'b1;
    Tx_Data_w  = d;
    tick();
    tx_data_en = 1'b0;
  endtask

  task automatic cmd(input logic v);
    tx_send_en = 1'b1;
    tx_send    = v;
    tick();
    tx_send_en = 1'b0;
    tx_send    = 1'b0;
  endtask

  // Samples one instance for ncyc cycles after a trigger; cycle 1 is the first after it.
  task automatic capture(input int idx, input int ncyc, output logic [7:0] d, output logic s9,
                         output int done_at, output int stop_n, output int first_low);
    d = 8'h00; s9 = 1'b0; done_at = -1; stop_n = 0; first_low = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!tx_w[idx] && first_low < 0) first_low = k;
      if (done_w[idx] && done_at < 0) done_at = k;
      if (stop_w[idx]) stop_n++;
      for (int s = 1; s <= 8; s++)
        if (k == 1 + B * s + 2) d[s-1] = tx_w[idx];
      if (k == 1 + B * 9 + 2) s9 = tx_w[idx];
    end
  endtask

  logic [7:0] d;
  logic       s9;
  int         done_at, stop_n, first_low;

  initial begin
    rst = 1'b0; tx_data_en = 1'b0; Tx_Data_w = 8'h00; tx_send_en = 1'b0; tx_send = 1'b0;
    repeat (3) tick();
    #1;
    chk("reset tx", tx_w[0], 1);
    chk("reset busy", busy_w[0], 0);
    rst = 1'b1;
    repeat (100) tick();
    chk("idle busy", busy_w[0], 0);

    // basic even-parity frame
    load(8'hA5);
    cmd(1'b1);
    capture(0, 48, d, s9, done_at, stop_n, first_low);
    chk("A5 first low", first_low, 1);
    chk("A5 data", d, 8'hA5);
    chk("A5 parity", s9, 0);
    chk("A5 done cycle", done_at, 44);
    chk("A5 stop cycles", stop_n, 4);

    // odd parity with 0x01
    load(8'h01);
    cmd(1'b1);
    capture(1, 48, d, s9, done_at, stop_n, first_low);
    chk("01 odd data", d, 8'h01);
    chk("01 odd parity", s9, 0);
    chk("01 odd done", done_at, 44);

    // no-parity frame with 0xFF
    load(8'hFF);
    cmd(1'b1);
    capture(2, 48, d, s9, done_at, stop_n, first_low);
    chk("FF nopar data", d, 8'hFF);
    chk("FF nopar slot9 is stop", s9, 1);
    chk("FF nopar done", done_at, 40);
    chk("FF nopar stop cycles", stop_n, 4);

    // send_en with send=0 starts nothing
    cmd(1'b0);
    repeat (20) tick();
    chk("send0 busy", busy_w[0], 0);

    // mid-frame send and load are not queued and do not disturb the frame
    load(8'h11);
    cmd(1'b1);
    repeat (10) tick();
    cmd(1'b1);
    load(8'h3C);
    repeat (60) tick();
    chk("no queued frame", busy_w, 0);
    cmd(1'b1);
    capture(0, 48, d, s9, done_at, stop_n, first_low);
    chk("3C data", d, 8'h3C);
    chk("3C done", done_at, 44);

    // bypass, then back-to-back trigger in the first IDLE cycle
    tx_data_en = 1'b1; Tx_Data_w = 8'h5A; tx_send_en = 1'b1; tx_send = 1'b1;
    tick();
    tx_data_en = 1'b0; tx_send_en = 1'b0; tx_send = 1'b0;
    capture(0, 44, d, s9, done_at, stop_n, first_low);
    chk("5A bypass data", d, 8'h5A);
    chk("5A done", done_at, 44);
    @(posedge clk);
    #1;
    tx_send_en = 1'b1; tx_send = 1'b1;
    @(negedge clk);
    chk("gap tx", tx_w[0], 1);
    chk("gap busy", busy_w[0], 0);
    @(posedge clk);
    #1;
    tx_send_en = 1'b0; tx_send = 1'b0;
    @(negedge clk);
    chk("b2b start tx", tx_w[0], 0);
    repeat (50) tick();

    // reset in the middle of data bit 3
    load(8'h0F);
    cmd(1'b1);
    repeat (18) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst mid tx", tx_w[0], 1);
    chk("rst mid busy", busy_w[0], 0);
    chk("rst mid done", done_w[0], 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    load(8'hC3);
    cmd(1'b1);
    capture(0, 48, d, s9, done_at, stop_n, first_low);
    chk("C3 after rst data", d, 8'hC3);
    chk("C3 after rst parity", s9, 0);
    chk("C3 after rst done", done_at, 44);
    chk("C3 first low", first_low, 1);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmitter driven by the core's memory-mapped UART registers: it takes the byte written to the Tx data register (0x10010034) and a send command written to 0x1001003C, and serializes them onto the tx line as 8N1 or 8E1/8O1. It is the transmit-side counterpart of the existing receiver, with a matching frame format and parity parameters. It returns the STOP-state flag that the core polls by reading 0x1001003C.

Parameters:
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range is 2 or more.
PARITY_EN, 1, 1 = insert a parity bit after the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
tx_data_en  input  1  load Tx_Data_w into the holding register
Tx_Data_w  input  8  byte to transmit
tx_send_en  input  1  write strobe to the send register
tx_send  input  1  send command value; a frame starts only when it is 1
tx  output  1  serial line, idle high
tx_busy  output  1  high whenever the FSM is not in IDLE
tx_fsm_in_STOP_S  output  1  high while the FSM is in STOP
tx_done  output  1  one-cycle pulse at the end of the stop bit

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; tx=1; tx_busy=0; tx_fsm_in_STOP_S=0; tx_done=0.
  - Holding register, shift register and baud/bit counters all clear to 0.
- Holding register: loads Tx_Data_w on any cycle with tx_data_en=1, in any state. Loading while a frame is in flight does not disturb that frame.
- Frame start:
  - Trigger: state=IDLE and tx_send_en=1 and tx_send=1.
  - The shift register loads from the holding register and parity is computed from it.
  - If tx_data_en is also 1 in the same cycle, the NEW Tx_Data_w byte is sent (bypass).
  - A send command outside IDLE is ignored. It is not queued.
- FSM states and transitions, each bit state lasting exactly BAUD_DIV cycles:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: 8 bits, LSB first; bit counter 0..7.
  - PARITY: only when PARITY_EN=1. tx = XOR(data) ^ PARITY_ODD.
  - STOP: tx=1; tx_fsm_in_STOP_S=1.
  - Back to IDLE.
- Latency: tx falls on the first clk edge after the trigger cycle (tx is a registered output).
- Frame length: (10 + PARITY_EN) * BAUD_DIV cycles from the tx falling edge to the return to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps to 0 on each state or bit advance.
  - Held at 0 in IDLE.
- tx_done: asserted for exactly one cycle, in the last cycle of STOP (baud counter = BAUD_DIV-1). The FSM is in IDLE on the next cycle.
- Back-to-back frames: a trigger in the first IDLE cycle after tx_done starts the next frame. The minimum idle gap is 1 cycle (tx=1).
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the frame is abandoned. No tx_done pulse is generated.
- tx_busy and tx_fsm_in_STOP_S are decoded from the state register. No glitches are allowed between states.

Test Plan:
1. Reset and idle (BAUD_DIV=4, PARITY_EN=1, PARITY_ODD=0): hold rst=0, then release with no stimulus -> tx=1, tx_busy=0, tx_done=0 for 100 cycles.
2. Basic frame: tx_data_en with 0xA5, then tx_send_en=1, tx_send=1.
   -> tx goes low the next cycle.
   -> Bits 1,0,1,0,0,1,0,1 at 4 cycles each; parity 0; stop 1.
   -> tx_fsm_in_STOP_S high for 4 cycles; tx_done pulse at cycle 44.
3. Odd/no parity: PARITY_ODD=1 sending 0x01 -> parity bit=0. PARITY_EN=0 sending 0xFF -> frame is 40 cycles with no parity slot.
4. Ignore conditions:
   - tx_send_en=1 with tx_send=0 -> no frame.
   - Send command mid-frame -> current frame is unaltered and no second frame follows.
   - tx_data_en=0x3C mid-frame -> current byte is unchanged; the next send transmits 0x3C.
5. Bypass and back-to-back: same-cycle tx_data_en=0x5A with a send -> 0x5A is transmitted. A second send in the cycle after tx_done -> exactly 1 idle cycle between stop and start.
6. Reset mid-DATA: assert rst at data bit 3 -> tx=1 in the same cycle, no tx_done, tx_busy=0. A send after release produces a clean full frame.
